// File: rtl/dmem_arb_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_arb_ctrl
// Arbitrates one shared data-memory port between a CPU data port and an
// external requester (loader/debugger). It also sequences the core through
// the BOOT, RUN and HALT states.
//
//   BOOT : core held in reset, external side owns the memory, writes counted
//   RUN  : CPU has priority, external side is served in CPU-idle cycles
//   HALT : core stalled, external side owns the memory
//
// Optional feature (macro DMEM_ARB_STALL_EN): a starvation counter. After
// WAIT_MAX consecutive starved RUN cycles it forces a one-cycle CPU stall and
// grants the external requester.
//
// Ports
//   clk, reset                      clock (rising edge), sync active-low reset
//   start_run, halt_req             state-change requests (levels)
//   ext_valid/we/addr/wdata         external command
//   ext_ready, ext_rvalid, ext_rdata external grant and read return
//   cpu_mem_req/we/addr/wdata       CPU command
//   cpu_rdata, cpu_reset, cpu_stall CPU read data and core control
//   mem_we/addr/wdata, mem_rdata    shared memory port (combinational read)
//   state, load_count               status: current state, BOOT write count
// -----------------------------------------------------------------------------
module dmem_arb_ctrl #(
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_run,
  input  logic        halt_req,
  input  logic        ext_valid,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_ready,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  input  logic        cpu_mem_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_reset,
  output logic        cpu_stall,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  state,
  output logic [15:0] load_count
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] loadCnt_q, loadCnt_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        forceStall;
  logic        grant;

  // Next-state logic: in HALT a simultaneous halt_req keeps the core halted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    if (start_run) state_d = RUN;
      RUN:     if (halt_req) state_d = HALT;
      HALT:    if (!halt_req && start_run) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef DMEM_ARB_STALL_EN
  localparam int unsigned CntW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  logic [CntW-1:0] waitCnt_q, waitCnt_d;

  // The stall is forced only while the CPU is actually blocking the requester.
  assign forceStall = (state_q == RUN) && ext_valid && cpu_mem_req &&
                      (waitCnt_q == CntW'(WAIT_MAX));

  // Counts consecutive starved RUN cycles. Any grant, a dropped request or
  // leaving RUN restarts the count.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if ((state_q != RUN) || (state_d != RUN) || !ext_valid || ext_ready) begin
      waitCnt_d = '0;
    end else begin
      waitCnt_d = waitCnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      waitCnt_q <= '0;
    end else begin
      waitCnt_q <= waitCnt_d;
    end
  end
`else
  // Without the starvation guard the CPU is never stalled in RUN.
  logic unusedWaitMax;
  assign forceStall    = 1'b0;
  assign unusedWaitMax = (WAIT_MAX == 0);
`endif

  // Core control and the external grant, decoded from the state.
  always_comb begin
    ext_ready = 1'b1;
    cpu_reset = 1'b0;
    cpu_stall = 1'b0;
    case (state_q)
      BOOT: begin
        cpu_reset = 1'b1;
      end
      RUN: begin
        ext_ready = ~cpu_mem_req | forceStall;
        cpu_stall = forceStall;
      end
      HALT: begin
        cpu_stall = 1'b1;
      end
      default: begin
        cpu_reset = 1'b1;
      end
    endcase
  end

  assign grant = ext_valid & ext_ready;

  // Memory port mux. The CPU can only write when it is out of reset and not
  // stalled, so an ungranted cycle never writes.
  always_comb begin
    mem_we    = cpu_we & cpu_mem_req & ~cpu_reset & ~cpu_stall;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (grant) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  assign cpu_rdata = mem_rdata;

  // BOOT write counter (saturating) and the one-cycle read return path.
  // ext_rdata holds between returns.
  always_comb begin
    loadCnt_d = loadCnt_q;
    rvalid_d  = grant & ~ext_we;
    rdata_d   = rdata_q;
    if ((state_q == BOOT) && grant && ext_we && (loadCnt_q != 16'hFFFF)) begin
      loadCnt_d = loadCnt_q + 16'd1;
    end
    if (grant && !ext_we) begin
      rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      loadCnt_q <= 16'd0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      loadCnt_q <= loadCnt_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign ext_rvalid = rvalid_q;
  assign ext_rdata  = rdata_q;
  assign state      = state_q;
  assign load_count = loadCnt_q;

endmodule

// File: tb/tb_dmem_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_arb_ctrl
// Directed bench for dmem_arb_ctrl with a small behavioural memory. Read
// returns are predicted into a queue and checked when ext_rvalid appears.
// Runs in both builds (DMEM_ARB_STALL_EN defined or not).
// -----------------------------------------------------------------------------
module tb_dmem_arb_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_run, halt_req;
  logic        ext_valid, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_ready, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        cpu_mem_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_reset, cpu_stall;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  state;
  logic [15:0] load_count;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] expQ[$];
  logic [31:0] monExp;
  logic [31:0] mem [0:31];

  always #5 clk = ~clk;

  dmem_arb_ctrl #(.WAIT_MAX(8)) dut (
    .clk(clk), .reset(reset), .start_run(start_run), .halt_req(halt_req),
    .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ready(ext_ready), .ext_rvalid(ext_rvalid),
    .ext_rdata(ext_rdata), .cpu_mem_req(cpu_mem_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_reset(cpu_reset), .cpu_stall(cpu_stall), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .state(state), .load_count(load_count)
  );

  // Behavioural memory: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr[6:2]];

  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_addr[6:2]] <= mem_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive all inputs just after the edge, then let them settle.
  task automatic applyStimulus(input logic rst, input logic sr, input logic hr,
                               input logic ev, input logic ew,
                               input logic [31:0] ea, input logic [31:0] ed,
                               input logic cr, input logic cw,
                               input logic [31:0] ca, input logic [31:0] cd);
    @(posedge clk);
    #1;
    reset       = rst;
    start_run   = sr;
    halt_req    = hr;
    ext_valid   = ev;
    ext_we      = ew;
    ext_addr    = ea;
    ext_wdata   = ed;
    cpu_mem_req = cr;
    cpu_we      = cw;
    cpu_addr    = ca;
    cpu_wdata   = cd;
    #3;
  endtask

  // Scoreboard side: every read return must match the oldest prediction.
  always @(negedge clk) begin
    if (ext_rvalid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("rvalid_unexpected", {31'd0, ext_rvalid}, 32'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("sb_ext_rdata", ext_rdata, monExp);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    reset = 1'b0; start_run = 1'b0; halt_req = 1'b0;
    ext_valid = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    cpu_mem_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Reset held for two edges.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_state", {30'd0, state}, 32'd0);
    checkOutput("rst_load_count", {16'd0, load_count}, 32'd0);
    checkOutput("rst_rvalid", {31'd0, ext_rvalid}, 32'd0);
    checkOutput("rst_rdata", ext_rdata, 32'd0);
    checkOutput("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    checkOutput("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("rst_ext_ready", {31'd0, ext_ready}, 32'd1);

    // Four BOOT writes while the (reset) CPU also asserts a write.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 1, 1, 32'(i * 4), 32'(32'h11 * (i + 1)),
                    1, 1, 32'h40, 32'hDEAD);
      checkOutput("boot_wr_mem_we", {31'd0, mem_we}, 32'd1);
      checkOutput("boot_wr_mem_addr", mem_addr, 32'(i * 4));
      checkOutput("boot_wr_mem_wdata", mem_wdata, 32'(32'h11 * (i + 1)));
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h40, 32'hDEAD);
    checkOutput("boot_cpu_gated_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("boot_load_count", {16'd0, load_count}, 32'd4);
    checkOutput("boot_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    // BOOT read does not count.
    applyStimulus(1, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0);
    expQ.push_back(32'h11);
    checkOutput("boot_rd_mem_we", {31'd0, mem_we}, 32'd0);

    // start_run together with a write to 0x10.
    applyStimulus(1, 1, 0, 1, 1, 32'h10, 32'h55, 0, 0, 0, 0);
    checkOutput("boot_rd_rvalid", {31'd0, ext_rvalid}, 32'd1);
    checkOutput("sr_state_still_boot", {30'd0, state}, 32'd0);
    checkOutput("sr_mem_we", {31'd0, mem_we}, 32'd1);
    checkOutput("sr_load_count", {16'd0, load_count}, 32'd4);

    // First RUN cycle: CPU writes 0xAA to 0x40.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h40, 32'hAA);
    checkOutput("run_state", {30'd0, state}, 32'd1);
    checkOutput("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    checkOutput("run_load_count", {16'd0, load_count}, 32'd5);
    checkOutput("run_ext_ready", {31'd0, ext_ready}, 32'd0);
    checkOutput("run_cpu_mem_we", {31'd0, mem_we}, 32'd1);
    checkOutput("run_cpu_mem_addr", mem_addr, 32'h40);
    checkOutput("run_rvalid_low", {31'd0, ext_rvalid}, 32'd0);

    // CPU busy continuously, external read of 0x4 pending.
`ifdef DMEM_ARB_STALL_EN
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 0, 1, 0, 32'h4, 0, 1, 0, 32'h40, 0);
      checkOutput("starve_ext_ready", {31'd0, ext_ready}, 32'd0);
      checkOutput("starve_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    end
    applyStimulus(1, 0, 0, 1, 0, 32'h4, 0, 1, 0, 32'h40, 0);
    checkOutput("force_ext_ready", {31'd0, ext_ready}, 32'd1);
    checkOutput("force_cpu_stall", {31'd0, cpu_stall}, 32'd1);
    checkOutput("force_mem_addr", mem_addr, 32'h4);
    checkOutput("force_cpu_rdata", cpu_rdata, 32'h22);
    expQ.push_back(32'h22);
`else
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 0, 1, 0, 32'h4, 0, 1, 0, 32'h40, 0);
      checkOutput("starve_ext_ready", {31'd0, ext_ready}, 32'd0);
      checkOutput("starve_cpu_stall", {31'd0, cpu_stall}, 32'd0);
      checkOutput("starve_cpu_rdata", cpu_rdata, 32'hAA);
    end
    applyStimulus(1, 0, 0, 1, 0, 32'h4, 0, 0, 0, 0, 0);
    checkOutput("idle_ext_ready", {31'd0, ext_ready}, 32'd1);
    expQ.push_back(32'h22);
`endif
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("starve_rd_rvalid", {31'd0, ext_rvalid}, 32'd1);

    // Back-to-back RUN reads; the last value holds afterwards.
    applyStimulus(1, 0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0);
    expQ.push_back(32'h11);
    applyStimulus(1, 0, 0, 1, 0, 32'h8, 0, 0, 0, 0, 0);
    expQ.push_back(32'h33);
    checkOutput("b2b_rvalid_1", {31'd0, ext_rvalid}, 32'd1);
    applyStimulus(1, 0, 0, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    expQ.push_back(32'h55);
    checkOutput("b2b_rvalid_2", {31'd0, ext_rvalid}, 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("b2b_rvalid_3", {31'd0, ext_rvalid}, 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("b2b_rvalid_off", {31'd0, ext_rvalid}, 32'd0);
    checkOutput("b2b_rdata_hold", ext_rdata, 32'h55);

    // RUN -> HALT; CPU write attempts in HALT must be blocked.
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h44, 32'hBB);
    checkOutput("halt_state", {30'd0, state}, 32'd2);
    checkOutput("halt_cpu_stall", {31'd0, cpu_stall}, 32'd1);
    checkOutput("halt_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    checkOutput("halt_mem_we", {31'd0, mem_we}, 32'd0);
    applyStimulus(1, 0, 0, 1, 0, 32'h8, 0, 1, 0, 32'h44, 0);
    checkOutput("halt_ext_ready", {31'd0, ext_ready}, 32'd1);
    expQ.push_back(32'h33);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("halt_rd_rvalid", {31'd0, ext_rvalid}, 32'd1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("halt_wins_state", {30'd0, state}, 32'd2);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h44, 0);
    checkOutput("resume_state", {30'd0, state}, 32'd1);
    checkOutput("resume_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    checkOutput("halt_no_write_0x44", cpu_rdata, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h40, 0);
    checkOutput("cpu_rdata_0x40", cpu_rdata, 32'hAA);

    // Read accepted in the same cycle reset is sampled low: no return.
    applyStimulus(0, 0, 0, 1, 0, 32'h4, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("abort_rvalid", {31'd0, ext_rvalid}, 32'd0);
    checkOutput("abort_state", {30'd0, state}, 32'd0);
    checkOutput("abort_load_count", {16'd0, load_count}, 32'd0);
    checkOutput("abort_rdata", ext_rdata, 32'd0);
    checkOutput("abort_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sb_queue_drained", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_arb_ctrl.md
DMEM_ARB_CTRL -- requirements
Module: dmem_arb_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 8, meaning the number of consecutive starved RUN cycles that triggers a forced CPU stall (used only with DMEM_ARB_STALL_EN).
REQ-002 SHALL have port clk  in  1  the single clock, rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start_run  in  1  level; BOOT->RUN or HALT->RUN request.
REQ-005 SHALL have port halt_req  in  1  level; RUN->HALT request.
REQ-006 SHALL have ports ext_valid in 1, ext_we in 1, ext_addr in 32, ext_wdata in 32  external requester command.
REQ-007 SHALL have ports ext_ready out 1, ext_rvalid out 1, ext_rdata out 32  external grant and read return.
REQ-008 SHALL have ports cpu_mem_req in 1, cpu_we in 1, cpu_addr in 32, cpu_wdata in 32  CPU data-port command.
REQ-009 SHALL have ports cpu_rdata out 32, cpu_reset out 1 (active-high to core), cpu_stall out 1.
REQ-010 SHALL have ports mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_rdata in 32  shared data-memory port; memory read is combinational.
REQ-011 SHALL have ports state out 2 (BOOT=00, RUN=01, HALT=10) and load_count out 16.

Function
REQ-012 Ext transfer SHALL occur in any cycle where ext_valid=1 and ext_ready=1; ext_ready SHALL be combinational.
REQ-013 BOOT: cpu_reset=1, cpu_stall=0, and ext_ready=1 in every cycle.
REQ-014 BOOT: load_count SHALL increment by 1 per accepted ext write, saturating at 0xFFFF; reads SHALL NOT count.
REQ-015 BOOT->RUN SHALL occur on the clock edge where start_run=1; a transfer accepted in the same cycle SHALL complete.
REQ-016 RUN: cpu_reset=0; CPU has priority; ext_ready=1 only when cpu_mem_req=0, or when a forced stall is active (REQ-027).
REQ-017 RUN->HALT SHALL occur on the edge where halt_req=1; HALT: cpu_stall=1, cpu_reset=0, ext_ready=1 every cycle.
REQ-018 HALT->RUN SHALL occur on start_run=1 with halt_req=0; halt_req=1 SHALL win if both are set.
REQ-019 Port mux: mem_we/mem_addr/mem_wdata SHALL come from ext when ext_ready & ext_valid, otherwise from CPU with mem_we=cpu_we & cpu_mem_req & ~cpu_reset & ~cpu_stall.
REQ-020 cpu_rdata SHALL equal mem_rdata combinationally, regardless of owner.
REQ-021 Ext read (ext_we=0) accepted in cycle N SHALL drive ext_rvalid=1 with ext_rdata=mem_rdata captured at N, in cycle N+1 only (latency 1).
REQ-022 ext_rdata SHALL hold its last value while ext_rvalid=0.
REQ-023 Back-to-back ext reads SHALL produce back-to-back ext_rvalid pulses.
REQ-024 No memory write SHALL occur in a cycle without a granted owner.

Reset
REQ-025 While reset=0 at a clock edge: state=BOOT, load_count=0, ext_rvalid=0, ext_rdata=0, starvation counter=0; cpu_reset=1 follows combinationally from BOOT.
REQ-026 Reset mid-operation SHALL abort any pending read return (no ext_rvalid the next cycle) and SHALL return to BOOT from any state.

Configuration
REQ-027 With macro DMEM_ARB_STALL_EN defined: a counter SHALL count RUN cycles with ext_valid=1 and ext_ready=0; when it equals WAIT_MAX, that cycle SHALL assert cpu_stall=1 and ext_ready=1, and the counter SHALL clear; the counter SHALL also clear on any grant, on ext_valid=0, or on leaving RUN.
REQ-028 Without DMEM_ARB_STALL_EN: no counter; cpu_stall=0 in RUN; ext SHALL be served only in CPU-idle cycles, and starvation is permitted.

Verification
REQ-029 Reset low 2 cycles, then 4 ext writes (addr 0x0,0x4,0x8,0xC; data 0x11..0x44) -> load_count=4, cpu_reset=1, mem_we pulses 4 times.
REQ-030 start_run=1 together with ext write (addr 0x10) -> write lands, state=01 next cycle, cpu_reset=0.
REQ-031 RUN, cpu_mem_req=1 continuously, ext read 0x4 pending; macro off -> ext_ready stays 0; macro on, WAIT_MAX=8 -> grant in the 9th cycle with cpu_stall=1, then ext_rvalid=1 with ext_rdata=0x22.
REQ-032 RUN, halt_req=1 -> state=10, cpu_stall=1; ext read 0x8 returns 0x33 one cycle later; start_run=1 with halt_req=0 -> state=01.
REQ-033 Ext read accepted, reset=0 on the next edge -> ext_rvalid stays 0, state=00, load_count=0.
